// File: rtl/pipe_control_if.sv
// Shared PC-select type and the datapath <-> pipeline-controller bundle.
// The controller side uses modport slave; the datapath/memory side uses modport master.
package pipe_control_pkg;
   typedef enum logic [1:0] {
      SEL_PC_NONE   = 2'd0,
      SEL_PC_SEQ    = 2'd1,
      SEL_PC_BRANCH = 2'd2,
      SEL_PC_JUMP   = 2'd3
   } sel_pc_t;
endpackage

interface pipe_control_if #(
   parameter int NUM_STALL_SRC = 2,
   parameter int ADDR_W        = 32
);
   logic [NUM_STALL_SRC-1:0]  done_i;
   pipe_control_pkg::sel_pc_t pc_sel_i;
   logic                      br_taken_i;
   logic [ADDR_W-1:0]         next_pc_i;
   logic                      halt_req_i;
   logic                      resume_i;
   logic                      fetch_stall_o;
   pipe_control_pkg::sel_pc_t pc_sel_o;
   logic                      br_taken_o;
   logic [ADDR_W-1:0]         next_pc_o;
   logic                      flush_o;
   logic [1:0]                state_o;
   logic [31:0]               stall_cnt_o;

   modport master (
      output done_i, pc_sel_i, br_taken_i, next_pc_i, halt_req_i, resume_i,
      input  fetch_stall_o, pc_sel_o, br_taken_o, next_pc_o, flush_o, state_o, stall_cnt_o
   );

   modport slave (
      input  done_i, pc_sel_i, br_taken_i, next_pc_i, halt_req_i, resume_i,
      output fetch_stall_o, pc_sel_o, br_taken_o, next_pc_o, flush_o, state_o, stall_cnt_o
   );
endinterface

// File: rtl/pipe_control.sv
// Pipeline sequencer: boot hold-off, memory stall gating, post-branch flush bubbles
// and halt/resume, plus a saturating count of stalled cycles.
module pipe_control #(
   parameter int              NUM_STALL_SRC = 2,
   parameter int              ADDR_W        = 32,
   parameter int              BOOT_CYCLES   = 1,
   parameter int              FLUSH_CYCLES  = 2,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
   input  logic           clk,
   input  logic           rst_n,
   pipe_control_if.slave  bus
);
   import pipe_control_pkg::*;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   state_t            state_reg, state_next;
   logic [7:0]        boot_cnt_reg, boot_cnt_next;
   logic [3:0]        flush_cnt_reg, flush_cnt_next;
   logic [ADDR_W-1:0] halt_pc_reg, halt_pc_next;
   logic [31:0]       stall_cnt_reg, stall_cnt_next;
   logic              busy;
   logic [31:0]       stall_cnt_inc;

   assign busy          = ~(&bus.done_i);
   assign stall_cnt_inc = (stall_cnt_reg == 32'hFFFF_FFFF) ? stall_cnt_reg : stall_cnt_reg + 32'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_BOOT;
         boot_cnt_reg  <= 8'(BOOT_CYCLES);
         flush_cnt_reg <= 4'd0;
         halt_pc_reg   <= '0;
         stall_cnt_reg <= 32'd0;
      end else begin
         state_reg     <= state_next;
         boot_cnt_reg  <= boot_cnt_next;
         flush_cnt_reg <= flush_cnt_next;
         halt_pc_reg   <= halt_pc_next;
         stall_cnt_reg <= stall_cnt_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      boot_cnt_next  = boot_cnt_reg;
      flush_cnt_next = flush_cnt_reg;
      halt_pc_next   = halt_pc_reg;
      stall_cnt_next = stall_cnt_reg;
      case (state_reg)
         ST_BOOT: begin
            boot_cnt_next = boot_cnt_reg - 8'd1;
            if (boot_cnt_reg == 8'd1) state_next = ST_RUN;
         end
         ST_RUN: begin
            // A stalled cycle hides both branch and halt; branch beats halt otherwise.
            if (busy) begin
               stall_cnt_next = stall_cnt_inc;
            end else if (bus.br_taken_i) begin
               if (FLUSH_CYCLES > 0) begin
                  state_next     = ST_FLUSH;
                  flush_cnt_next = 4'(FLUSH_CYCLES);
               end
            end else if (bus.halt_req_i) begin
               state_next   = ST_HALT;
               halt_pc_next = bus.next_pc_i;
            end
         end
         ST_FLUSH: begin
            if (busy) begin
               stall_cnt_next = stall_cnt_inc;
            end else begin
               flush_cnt_next = flush_cnt_reg - 4'd1;
               if (flush_cnt_reg == 4'd1) state_next = ST_RUN;
            end
         end
         ST_HALT: begin
            if (bus.resume_i) state_next = ST_RUN;
         end
         default: state_next = ST_BOOT;
      endcase
   end

   always_comb begin
      bus.fetch_stall_o = 1'b1;
      bus.pc_sel_o      = SEL_PC_NONE;
      bus.br_taken_o    = 1'b0;
      bus.next_pc_o     = RESET_PC;
      bus.flush_o       = 1'b0;
      case (state_reg)
         ST_RUN: begin
            bus.fetch_stall_o = busy;
            bus.pc_sel_o      = bus.pc_sel_i;
            bus.br_taken_o    = bus.br_taken_i;
            bus.next_pc_o     = bus.next_pc_i;
         end
         ST_FLUSH: begin
            bus.fetch_stall_o = busy;
            bus.pc_sel_o      = bus.pc_sel_i;
            bus.next_pc_o     = bus.next_pc_i;
            bus.flush_o       = 1'b1;
         end
         ST_HALT: begin
            bus.next_pc_o = halt_pc_reg;
         end
         default: ;
      endcase
   end

   assign bus.state_o     = state_reg;
   assign bus.stall_cnt_o = stall_cnt_reg;
endmodule

// File: tb/tb_pipe_control.sv
// Directed scenario bench for pipe_control: boot, stalls, flush, halt/resume,
// branch-over-halt priority and asynchronous reset mid-halt.
module tb_pipe_control;
   import pipe_control_pkg::*;

   logic clk;
   logic rst_n;
   int   pass_cnt;
   int   total_cnt;

   pipe_control_if #(.NUM_STALL_SRC(2), .ADDR_W(32)) bus ();

   pipe_control #(
      .NUM_STALL_SRC(2), .ADDR_W(32), .BOOT_CYCLES(1), .FLUSH_CYCLES(2), .RESET_PC(32'h0)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge; inputs set here apply to the following edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      bus.done_i     = 2'b11;
      bus.pc_sel_i   = SEL_PC_SEQ;
      bus.br_taken_i = 1'b0;
      bus.next_pc_i  = 32'hDEAD_0000;
      bus.halt_req_i = 1'b0;
      bus.resume_i   = 1'b0;
      #3;
      total_cnt++; if (bus.state_o !== 2'd0) $display("FAIL reset_state: got %0d want 0", bus.state_o); else pass_cnt++;
      total_cnt++; if (bus.stall_cnt_o !== 32'd0) $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_cnt_o); else pass_cnt++;
      total_cnt++; if (bus.fetch_stall_o !== 1'b1) $display("FAIL reset_fetch_stall: got %0b want 1", bus.fetch_stall_o); else pass_cnt++;
      cyc(); cyc();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total_cnt++; if (bus.state_o !== 2'd0) $display("FAIL boot_state: got %0d want 0", bus.state_o); else pass_cnt++;
      total_cnt++; if (bus.pc_sel_o !== SEL_PC_NONE) $display("FAIL boot_pc_sel: got %0d want 0", bus.pc_sel_o); else pass_cnt++;
      total_cnt++; if (bus.next_pc_o !== 32'h0) $display("FAIL boot_next_pc: got %0h want 0", bus.next_pc_o); else pass_cnt++;
      cyc();
      bus.next_pc_i = 32'h44;
      #1;
      total_cnt++; if (bus.state_o !== 2'd1) $display("FAIL run_state: got %0d want 1", bus.state_o); else pass_cnt++;
      total_cnt++; if (bus.next_pc_o !== 32'h44) $display("FAIL run_next_pc: got %0h want 44", bus.next_pc_o); else pass_cnt++;
      total_cnt++; if (bus.pc_sel_o !== SEL_PC_SEQ) $display("FAIL run_pc_sel: got %0d want 1", bus.pc_sel_o); else pass_cnt++;
      total_cnt++; if (bus.fetch_stall_o !== 1'b0) $display("FAIL run_fetch_stall: got %0b want 0", bus.fetch_stall_o); else pass_cnt++;
      $display("test_reset: %0d/%0d so far", pass_cnt, total_cnt);
   endtask

   task automatic test_stall();
      // Three busy cycles; branch and halt requests during them must be ignored.
      for (int i = 0; i < 3; i++) begin
         cyc();
         bus.done_i     = 2'b10;
         bus.br_taken_i = (i == 1);
         bus.halt_req_i = (i == 2);
         #1;
         total_cnt++; if (bus.fetch_stall_o !== 1'b1) $display("FAIL stall_fetch_%0d: got %0b want 1", i, bus.fetch_stall_o); else pass_cnt++;
      end
      cyc();
      bus.done_i     = 2'b11;
      bus.br_taken_i = 1'b0;
      bus.halt_req_i = 1'b0;
      #1;
      total_cnt++; if (bus.fetch_stall_o !== 1'b0) $display("FAIL stall_release: got %0b want 0", bus.fetch_stall_o); else pass_cnt++;
      total_cnt++; if (bus.stall_cnt_o !== 32'd3) $display("FAIL stall_cnt: got %0d want 3", bus.stall_cnt_o); else pass_cnt++;
      total_cnt++; if (bus.state_o !== 2'd1) $display("FAIL stall_state: got %0d want 1", bus.state_o); else pass_cnt++;
      $display("test_stall: %0d/%0d so far", pass_cnt, total_cnt);
   endtask

   task automatic test_flush();
      logic [1:0] exp_state [0:3];
      logic [1:0] done_seq  [0:3];
      bus.br_taken_i = 1'b1;
      bus.pc_sel_i   = SEL_PC_BRANCH;
      #1;
      total_cnt++; if (bus.br_taken_o !== 1'b1) $display("FAIL branch_pass: got %0b want 1", bus.br_taken_o); else pass_cnt++;
      total_cnt++; if (bus.pc_sel_o !== SEL_PC_BRANCH) $display("FAIL branch_pc_sel: got %0d want 2", bus.pc_sel_o); else pass_cnt++;
      // Plain flush: two bubbles, br_taken_i held high in the first to check gating.
      exp_state = '{2'd2, 2'd2, 2'd1, 2'd1};
      for (int i = 0; i < 3; i++) begin
         cyc();
         bus.br_taken_i = (i == 0);
         #1;
         total_cnt++; if (bus.state_o !== exp_state[i]) $display("FAIL flush_state_%0d: got %0d want %0d", i, bus.state_o, exp_state[i]); else pass_cnt++;
         total_cnt++; if (bus.flush_o !== (exp_state[i] == 2'd2)) $display("FAIL flush_o_%0d: got %0b want %0b", i, bus.flush_o, exp_state[i] == 2'd2); else pass_cnt++;
         total_cnt++; if (bus.br_taken_o !== ((exp_state[i] == 2'd1) & bus.br_taken_i)) $display("FAIL flush_br_gate_%0d: got %0b", i, bus.br_taken_o); else pass_cnt++;
      end
      // Stalled first bubble stretches the flush to three cycles.
      bus.br_taken_i = 1'b1;
      exp_state = '{2'd2, 2'd2, 2'd2, 2'd1};
      done_seq  = '{2'b01, 2'b11, 2'b11, 2'b11};
      for (int i = 0; i < 4; i++) begin
         cyc();
         bus.br_taken_i = 1'b0;
         bus.done_i     = done_seq[i];
         #1;
         total_cnt++; if (bus.state_o !== exp_state[i]) $display("FAIL flush_ext_state_%0d: got %0d want %0d", i, bus.state_o, exp_state[i]); else pass_cnt++;
         total_cnt++; if (bus.flush_o !== (exp_state[i] == 2'd2)) $display("FAIL flush_ext_o_%0d: got %0b want %0b", i, bus.flush_o, exp_state[i] == 2'd2); else pass_cnt++;
      end
      total_cnt++; if (bus.stall_cnt_o !== 32'd4) $display("FAIL flush_stall_cnt: got %0d want 4", bus.stall_cnt_o); else pass_cnt++;
      $display("test_flush: %0d/%0d so far", pass_cnt, total_cnt);
   endtask

   task automatic test_halt();
      bus.next_pc_i  = 32'h100;
      bus.halt_req_i = 1'b1;
      cyc();
      bus.halt_req_i = 1'b0;
      bus.next_pc_i  = 32'h200;
      #1;
      total_cnt++; if (bus.state_o !== 2'd3) $display("FAIL halt_state: got %0d want 3", bus.state_o); else pass_cnt++;
      total_cnt++; if (bus.next_pc_o !== 32'h100) $display("FAIL halt_pc: got %0h want 100", bus.next_pc_o); else pass_cnt++;
      total_cnt++; if (bus.fetch_stall_o !== 1'b1) $display("FAIL halt_fetch_stall: got %0b want 1", bus.fetch_stall_o); else pass_cnt++;
      total_cnt++; if (bus.pc_sel_o !== SEL_PC_NONE) $display("FAIL halt_pc_sel: got %0d want 0", bus.pc_sel_o); else pass_cnt++;
      cyc();
      bus.resume_i = 1'b1;
      #1;
      total_cnt++; if (bus.state_o !== 2'd3) $display("FAIL halt_hold: got %0d want 3", bus.state_o); else pass_cnt++;
      total_cnt++; if (bus.next_pc_o !== 32'h100) $display("FAIL halt_hold_pc: got %0h want 100", bus.next_pc_o); else pass_cnt++;
      cyc();
      bus.resume_i = 1'b0;
      #1;
      total_cnt++; if (bus.state_o !== 2'd1) $display("FAIL resume_state: got %0d want 1", bus.state_o); else pass_cnt++;
      total_cnt++; if (bus.next_pc_o !== 32'h200) $display("FAIL resume_next_pc: got %0h want 200", bus.next_pc_o); else pass_cnt++;
      $display("test_halt: %0d/%0d so far", pass_cnt, total_cnt);
   endtask

   task automatic test_branch_halt();
      logic [1:0] exp_state [0:3];
      exp_state = '{2'd2, 2'd2, 2'd1, 2'd3};
      bus.br_taken_i = 1'b1;
      bus.halt_req_i = 1'b1;
      bus.next_pc_i  = 32'h300;
      for (int i = 0; i < 4; i++) begin
         cyc();
         bus.br_taken_i = 1'b0;
         #1;
         total_cnt++; if (bus.state_o !== exp_state[i]) $display("FAIL br_halt_state_%0d: got %0d want %0d", i, bus.state_o, exp_state[i]); else pass_cnt++;
      end
      total_cnt++; if (bus.next_pc_o !== 32'h300) $display("FAIL br_halt_pc: got %0h want 300", bus.next_pc_o); else pass_cnt++;
      $display("test_branch_halt: %0d/%0d so far", pass_cnt, total_cnt);
   endtask

   task automatic test_async_reset();
      // Still in HALT from the previous scenario, with a nonzero stall count.
      bus.halt_req_i = 1'b0;
      bus.next_pc_i  = 32'h404;
      cyc();
      #1;
      total_cnt++; if (bus.state_o !== 2'd3) $display("FAIL pre_reset_state: got %0d want 3", bus.state_o); else pass_cnt++;
      rst_n = 1'b0;
      #1;
      total_cnt++; if (bus.state_o !== 2'd0) $display("FAIL async_state: got %0d want 0", bus.state_o); else pass_cnt++;
      total_cnt++; if (bus.stall_cnt_o !== 32'd0) $display("FAIL async_stall_cnt: got %0d want 0", bus.stall_cnt_o); else pass_cnt++;
      total_cnt++; if (bus.next_pc_o !== 32'h0) $display("FAIL async_next_pc: got %0h want 0", bus.next_pc_o); else pass_cnt++;
      total_cnt++; if (bus.fetch_stall_o !== 1'b1) $display("FAIL async_fetch_stall: got %0b want 1", bus.fetch_stall_o); else pass_cnt++;
      cyc();
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      #1;
      total_cnt++; if (bus.state_o !== 2'd1) $display("FAIL reboot_state: got %0d want 1", bus.state_o); else pass_cnt++;
      total_cnt++; if (bus.next_pc_o !== 32'h404) $display("FAIL reboot_next_pc: got %0h want 404", bus.next_pc_o); else pass_cnt++;
      $display("test_async_reset: %0d/%0d so far", pass_cnt, total_cnt);
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_stall();
      test_flush();
      test_halt();
      test_branch_halt();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
